// File: rtl/spi_regbank.sv
// Register bank behind the SPI register-access slave: CTRL/CFG, sticky EVT, ID, lock FSM, fast commands.
// Latency: rd_data/status are combinational from state; writes land at the strobe edge; irq_o/trig_o are one cycle later.
// Backpressure: none; every wr_vld/fastcmd_vld strobe is consumed in its cycle (rejected writes raise wr_err).
//
// Ports: clk/nrst (async active-low); reg_addr/wr_data/wr_vld write port; fastcmd/fastcmd_vld command port;
//        event_i level events; rd_data read mux; status {lock[1:0], wr_err, |evt, irq_en, fastcmd count};
//        cfg_o packed CTRL (LSB) then CFG1..; irq_o registered interrupt; trig_o one-cycle trigger pulse.
module spi_regbank #(
    parameter int               ADDR_W  = 3,
    parameter int               REG_W   = 8,
    parameter logic [REG_W-1:0] ID_VAL  = REG_W'('hA5),
    parameter logic [REG_W-1:0] CFG_RST = '0
) (
    input  logic                                 clk,
    input  logic                                 nrst,
    input  logic [ADDR_W-1:0]                    reg_addr,
    input  logic [REG_W-1:0]                     wr_data,
    input  logic                                 wr_vld,
    input  logic [5:0]                           fastcmd,
    input  logic                                 fastcmd_vld,
    input  logic [REG_W-1:0]                     event_i,
    output logic [REG_W-1:0]                     rd_data,
    output logic [7:0]                           status,
    output logic [((2**ADDR_W)-2)*REG_W-1:0]     cfg_o,
    output logic                                 irq_o,
    output logic                                 trig_o
);
    localparam int NUM_REGS = 2**ADDR_W;
    localparam int NUM_CFG  = NUM_REGS - 2;   // CTRL plus CFG1..CFG(NUM_REGS-3)

    localparam logic [ADDR_W-1:0] EVT_ADDR = ADDR_W'(NUM_REGS - 2);
    localparam logic [ADDR_W-1:0] ID_ADDR  = ADDR_W'(NUM_REGS - 1);

    localparam logic [5:0] FC_SRST = 6'h01;
    localparam logic [5:0] FC_CLR  = 6'h02;
    localparam logic [5:0] FC_LOCK = 6'h04;
    localparam logic [5:0] FC_TRIG = 6'h05;
    localparam logic [5:0] FC_ARM  = 6'h2A;
    localparam logic [5:0] FC_UNLK = 6'h15;

    typedef enum logic [1:0] {
        LOCKED   = 2'b00,
        ARMED    = 2'b01,
        UNLOCKED = 2'b10
    } lock_t;

    logic [NUM_CFG-1:0][REG_W-1:0] cfg_q;
    logic [REG_W-1:0]              evt_q;
    logic                          wr_err_q;
    lock_t                         lock_q;
    logic [2:0]                    fc_cnt_q;

    logic             is_srst;
    logic             is_clr;
    logic             is_lock;
    logic             is_trig;
    logic             addr_evt;
    logic             addr_id;
    logic             addr_cfg;
    logic             wr_cfg_ok;
    logic             wr_drop;
    logic [REG_W-1:0] evt_clr;

    assign is_srst = fastcmd_vld && (fastcmd == FC_SRST);
    assign is_clr  = fastcmd_vld && (fastcmd == FC_CLR);
    assign is_lock = fastcmd_vld && (fastcmd == FC_LOCK);
    assign is_trig = fastcmd_vld && (fastcmd == FC_TRIG);

    assign addr_evt = (reg_addr == EVT_ADDR);
    assign addr_id  = (reg_addr == ID_ADDR);
    assign addr_cfg = !addr_evt && !addr_id;

    // Write permission uses the state before this edge, so the write that
    // aborts ARMED is refused as well (ARMED is never UNLOCKED).
    assign wr_cfg_ok = wr_vld && addr_cfg && (lock_q == UNLOCKED);
    assign wr_drop   = wr_vld && (addr_id || (addr_cfg && (lock_q != UNLOCKED)));

    // EVT writes are always honoured, independent of the lock state.
    assign evt_clr = ({REG_W{wr_vld && addr_evt}} & wr_data) | {REG_W{is_clr}};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cfg_q    <= {NUM_CFG{CFG_RST}};
            evt_q    <= '0;
            wr_err_q <= 1'b0;
            lock_q   <= LOCKED;
            fc_cnt_q <= 3'd0;
            irq_o    <= 1'b0;
            trig_o   <= 1'b0;
        end else if (is_srst) begin
            // Soft reset swallows any coincident write and its own count.
            cfg_q    <= {NUM_CFG{CFG_RST}};
            evt_q    <= '0;
            wr_err_q <= 1'b0;
            lock_q   <= LOCKED;
            fc_cnt_q <= 3'd0;
            irq_o    <= 1'b0;
            trig_o   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (wr_cfg_ok && (reg_addr == ADDR_W'(i))) begin
                    cfg_q[i] <= wr_data;
                end
            end

            // New events win over a clear landing in the same cycle.
            evt_q <= (evt_q & ~evt_clr) | event_i;

            // A refused write is reported even if CLR arrives alongside it.
            wr_err_q <= (wr_err_q && !is_clr) || wr_drop;

            case (lock_q)
                LOCKED: begin
                    if (fastcmd_vld && (fastcmd == FC_ARM)) begin
                        lock_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (wr_vld) begin
                        lock_q <= LOCKED;
                    end else if (fastcmd_vld) begin
                        lock_q <= (fastcmd == FC_UNLK) ? UNLOCKED : LOCKED;
                    end
                end
                UNLOCKED: begin
                    if (is_lock) begin
                        lock_q <= LOCKED;
                    end
                end
                default: lock_q <= LOCKED;
            endcase

            if (fastcmd_vld) begin
                fc_cnt_q <= fc_cnt_q + 3'd1;
            end

            irq_o  <= cfg_q[0][0] && (|evt_q);
            trig_o <= is_trig;
        end
    end

    always_comb begin
        rd_data = '0;
        if (addr_evt) begin
            rd_data = evt_q;
        end else if (addr_id) begin
            rd_data = ID_VAL;
        end else begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (reg_addr == ADDR_W'(i)) begin
                    rd_data = cfg_q[i];
                end
            end
        end
    end

    assign status = {lock_q, wr_err_q, |evt_q, cfg_q[0][0], fc_cnt_q};
    assign cfg_o  = cfg_q;

endmodule
